bnn_xnor_acc: RTL

- Downstream consumer of the layer's 16-bit chunk counter.
- Per neuron, accepts num_chunks+1 beats of activation/weight words and accumulates the XNOR-popcount.
- Compares the total against a per-neuron threshold to produce one binary activation bit.
- Packs OUT_W successive neuron bits into an output word, handed off with a valid/ready handshake to the next layer's input buffer.

---
 rtl/bnn_xnor_acc.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bnn_xnor_acc.sv
// bnn_xnor_acc -- binary neural network XNOR-popcount accumulator.
//
// For each neuron it takes num_chunks+1 beats of activation/weight words and
// sums popcount(~(act ^ wgt)) over all of them. It then compares the sum
// against the neuron's threshold to make one activation bit. OUT_W successive
// bits are packed (neuron 0 in bit 0) into an output word. That word goes out
// with a valid/ready handshake.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-low reset
//   start             begin one neuron (sampled in IDLE only)
//   num_chunks        beats per neuron minus 1, latched on start
//   threshold         activation threshold, latched on start
//   in_valid/in_ready beat handshake for act_word/wgt_word
//   flush             emit a partially filled word (sampled in IDLE only)
//   busy              high in any state other than IDLE
//   bit_valid/bit_out one-cycle pulse with the newest neuron activation
//   out_valid/out_ready/out_word  packed-word handshake
//   chunk_idx         current beat index within the neuron
//
// Build option:
//   BNN_ACC_SAT_EN    defined: accumulator saturates at 2^ACC_W-1;
//                     undefined: accumulator wraps modulo 2^ACC_W.

module bnn_xnor_acc #(
  parameter int WORD_W = 32,
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_chunks,
  input  logic [ACC_W-1:0]  threshold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] act_word,
  input  logic [WORD_W-1:0] wgt_word,
  input  logic              flush,
  output logic              busy,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_word,
  output logic [15:0]       chunk_idx
);

  localparam int PC_W  = $clog2(WORD_W + 1);
  localparam int CNT_W = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, OUT} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W-1:0]   thr_q;
  logic [15:0]        nc_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [WORD_W-1:0]  xn;
  logic [PC_W-1:0]    pc;
  logic               dec_bit;

  // XNOR marks matching bit positions; the popcount is the match count.
  assign xn = ~(act_word ^ wgt_word);

  always_comb begin
    pc = '0;
    for (int i = 0; i < WORD_W; i++)
      pc = pc + PC_W'(xn[i]);
  end

`ifdef BNN_ACC_SAT_EN
  // One extra carry bit detects overflow; clamp to all-ones instead of wrapping.
  logic [ACC_W:0] sum_w;
  assign sum_w    = {1'b0, acc} + (ACC_W+1)'(pc);
  assign acc_next = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
  assign acc_next = acc + ACC_W'(pc);
`endif

  assign dec_bit = (acc >= thr_q);
  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
      chunk_idx <= '0;
      acc       <= '0;
      cnt       <= '0;
      nc_q      <= '0;
      thr_q     <= '0;
    end else begin
      bit_valid <= 1'b0;
      case (state)
        IDLE: begin
          // start has priority; a simultaneous flush is dropped
          if (start) begin
            nc_q      <= num_chunks;
            thr_q     <= threshold;
            acc       <= '0;
            chunk_idx <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCUM;
          end else if (flush && cnt != '0) begin
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= OUT;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            acc <= acc_next;
            // end-count compare: the beat at index nc_q is the last one
            if (chunk_idx == nc_q) begin
              in_ready <= 1'b0;
              state    <= DECIDE;
            end else begin
              chunk_idx <= chunk_idx + 16'd1;
            end
          end
        end
        DECIDE: begin
          bit_out   <= dec_bit;
          bit_valid <= 1'b1;
          out_word  <= out_word | (OUT_W'(dec_bit) << cnt);
          cnt       <= cnt_inc;
          if (cnt_inc == CNT_W'(OUT_W)) begin
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_word  <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
